// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifetch_unit_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response and decode-side signals of the fetch stage.
interface ifetch_unit_if #(
  parameter int ADDR_W = ifetch_unit_pkg::FETCH_ADDR_W,
  parameter int DATA_W = ifetch_unit_pkg::FETCH_DATA_W
);

  // valid/ready: a transfer happens on a rising edge where both are high; the
  // sender keeps valid and payload stable until ready. The response has no ready.
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_resp_valid;
  logic [DATA_W-1:0] imem_resp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst_out;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, inst_out, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, inst_out, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
  );

endinterface

// File: rtl/ifetch_buf.sv
// DEPTH-entry synchronous FIFO of {pc, inst} with flush; head is read combinationally.
module ifetch_buf #(
  parameter  int DEPTH = 2,
  parameter  int W     = 64,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: one outstanding imem read, buffered results to decode, PC enable and redirect flush.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_ena,
  input  logic              redirect,
  ifetch_unit_if.master     bus,
  output fetch_state_t      fsm_state
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W  = ADDR_W + DATA_W;

  fetch_state_t      state;
  fetch_state_t      state_nx;
  logic [ADDR_W-1:0] pending_pc;
  logic [CW-1:0]     count;
  logic [W-1:0]      head;
  logic              req_fire;
  logic              push;
  logic              pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending_pc <= '0;
    end else begin
      state <= state_nx;
      if (req_fire) pending_pc <= pc_in;
    end
  end

  // Count is checked before any same-cycle pop, so a slot is always free for the response.
  always_comb begin
    state_nx           = state;
    push               = 1'b0;
    bus.imem_req_valid = !rst && (state == IDLE) && (count < CW'(DEPTH)) && !redirect;
    req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    pc_ena             = !rst && (req_fire || redirect);
    case (state)
      IDLE:  if (req_fire) state_nx = WAIT;
      WAIT: begin
        if (bus.imem_resp_valid) begin
          push     = !rst && !redirect;
          state_nx = IDLE;
        end else if (redirect) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: if (bus.imem_resp_valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.inst_valid = !rst && (count != '0) && !redirect;
  assign pop            = bus.inst_valid && bus.inst_ready;

  ifetch_buf #(.DEPTH(DEPTH), .W(W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data ({pending_pc, bus.imem_resp_data}),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

  assign bus.imem_addr = rst ? '0 : {pc_in[ADDR_W-1:2], 2'b00};
  assign bus.inst_out  = rst ? DATA_W'(NOP_INST) : head[DATA_W-1:0];
  assign bus.inst_pc   = rst ? '0 : head[W-1:DATA_W];
  assign fsm_state     = state;

  // A response with nothing outstanding means the memory broke the protocol.
  always @(posedge clk) begin
    if (!rst && state == IDLE) assert (!bus.imem_resp_valid);
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: fetch, stall, slow memory, redirects and mid-operation reset.
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  logic         clk;
  logic         rst;
  logic [31:0]  pc_in;
  logic         pc_ena;
  logic         redirect;
  fetch_state_t fsm_state;
  int           n_cmp;
  int           n_err;
  logic [31:0]  exp_q[$];

  ifetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ifetch_unit #(.DEPTH(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .pc_ena    (pc_ena),
    .redirect  (redirect),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required summary before 200us");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic drive_quiet();
    redirect            = 1'b0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    bus.inst_ready      = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; drive_quiet(); pc_in = 32'h0040_0000; bus.imem_req_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    n_cmp++; if (pc_ena !== 1'b0) begin n_err++; $display("FAIL reset_pc_ena: got %0b required 0", pc_ena); end
    n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_req_valid: got %0b required 0", bus.imem_req_valid); end
    n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h required 0", bus.imem_addr); end
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_inst_valid: got %0b required 0", bus.inst_valid); end
    n_cmp++; if (bus.inst_out !== 32'h0) begin n_err++; $display("FAIL reset_inst_out: got %h required 0", bus.inst_out); end
    n_cmp++; if (bus.inst_pc !== 32'h0) begin n_err++; $display("FAIL reset_inst_pc: got %h required 0", bus.inst_pc); end
    n_cmp++; if (fsm_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d required IDLE", fsm_state); end
  endtask

  task automatic test_basic_fetch();
    @(negedge clk);
    rst = 1'b0; drive_quiet(); pc_in = 32'h0040_0000; bus.imem_req_ready = 1'b1;
    #1;
    n_cmp++; if (bus.imem_req_valid !== 1'b1) begin n_err++; $display("FAIL basic_req_valid: got %0b required 1", bus.imem_req_valid); end
    n_cmp++; if (pc_ena !== 1'b1) begin n_err++; $display("FAIL basic_pc_ena: got %0b required 1", pc_ena); end
    n_cmp++; if (bus.imem_addr !== 32'h0040_0000) begin n_err++; $display("FAIL basic_addr: got %h required 00400000", bus.imem_addr); end
    @(negedge clk);
    pc_in = 32'h0040_0004; bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h2408_0005;
    #1;
    n_cmp++; if (pc_ena !== 1'b0) begin n_err++; $display("FAIL basic_pc_ena_wait: got %0b required 0", pc_ena); end
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_early: got %0b required 0", bus.inst_valid); end
    @(negedge clk);
    bus.imem_resp_valid = 1'b0; bus.imem_req_ready = 1'b0;
    #1;
    n_cmp++; if (bus.inst_valid !== 1'b1) begin n_err++; $display("FAIL basic_inst_valid: got %0b required 1", bus.inst_valid); end
    n_cmp++; if (bus.inst_out !== 32'h2408_0005) begin n_err++; $display("FAIL basic_inst_out: got %h required 24080005", bus.inst_out); end
    n_cmp++; if (bus.inst_pc !== 32'h0040_0000) begin n_err++; $display("FAIL basic_inst_pc: got %h required 00400000", bus.inst_pc); end
    n_cmp++; if (pc_ena !== 1'b0) begin n_err++; $display("FAIL basic_pc_ena_once: got %0b required 0", pc_ena); end
    @(negedge clk);
    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    #1;
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL basic_after_pop: got %0b required 0", bus.inst_valid); end
  endtask

  task automatic test_stall();
    logic        pend;
    logic        ena_d;
    logic [31:0] last_addr;
    int          pulses;
    logic [31:0] e;
    pend = 1'b0; ena_d = 1'b0; last_addr = 32'h0; pulses = 0;
    exp_q.delete();
    @(negedge clk);
    drive_quiet(); pc_in = 32'h0040_0000; bus.imem_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (ena_d) pc_in = pc_in + 32'd4;
      bus.imem_resp_valid = pend;
      bus.imem_resp_data  = pend ? mem_word(last_addr) : 32'h0;
      #1;
      ena_d = pc_ena;
      if (pc_ena) pulses++;
      pend = bus.imem_req_valid && bus.imem_req_ready;
      if (pend) begin last_addr = pc_in; exp_q.push_back(pc_in); end
      if (i >= 2) begin
        n_cmp++;
        if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0040_0000) begin
          n_err++; $display("FAIL stall_head_c%0d: got valid=%0b pc=%h required valid=1 pc=00400000", i, bus.inst_valid, bus.inst_pc);
        end
      end
    end
    n_cmp++; if (pulses != 2) begin n_err++; $display("FAIL stall_pc_ena_pulses: got %0d required 2", pulses); end
    n_cmp++; if (bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL stall_full_req: got %0b required 0", bus.imem_req_valid); end
    n_cmp++; if (exp_q.size() != 2) begin n_err++; $display("FAIL stall_req_count: got %0d required 2", exp_q.size()); end
    @(negedge clk);
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.inst_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      n_cmp++;
      if (bus.inst_valid !== 1'b1 || bus.inst_pc !== e || bus.inst_out !== mem_word(e)) begin
        n_err++; $display("FAIL stall_pop%0d: got valid=%0b pc=%h inst=%h required valid=1 pc=%h inst=%h",
                          i, bus.inst_valid, bus.inst_pc, bus.inst_out, e, mem_word(e));
      end
    end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL stall_empty: got %0b required 0", bus.inst_valid); end
    bus.inst_ready = 1'b0;
  endtask

  task automatic test_slow_memory();
    @(negedge clk);
    drive_quiet(); pc_in = 32'h0040_0200;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_cmp++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0040_0200 || pc_ena !== 1'b0) begin
        n_err++; $display("FAIL slow_hold_c%0d: got valid=%0b addr=%h ena=%0b required 1 00400200 0", i, bus.imem_req_valid, bus.imem_addr, pc_ena);
      end
    end
    @(negedge clk);
    bus.imem_req_ready = 1'b1;
    #1;
    n_cmp++; if (pc_ena !== 1'b1) begin n_err++; $display("FAIL slow_accept_ena: got %0b required 1", pc_ena); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pc_in = 32'h0040_0204; bus.imem_req_ready = 1'b0;
      bus.imem_resp_valid = (i == 3); bus.imem_resp_data = 32'h1234_5678;
      #1;
      n_cmp++;
      if (fsm_state !== WAIT || pc_ena !== 1'b0 || bus.inst_valid !== 1'b0) begin
        n_err++; $display("FAIL slow_wait_c%0d: got state=%0d ena=%0b valid=%0b required WAIT 0 0", i, fsm_state, pc_ena, bus.inst_valid);
      end
    end
    @(negedge clk);
    bus.imem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0040_0200 || bus.inst_out !== 32'h1234_5678 || fsm_state !== IDLE) begin
      n_err++; $display("FAIL slow_push: got valid=%0b pc=%h inst=%h state=%0d required 1 00400200 12345678 IDLE",
                        bus.inst_valid, bus.inst_pc, bus.inst_out, fsm_state);
    end
    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    #1;
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL slow_single_push: got %0b required 0", bus.inst_valid); end
  endtask

  task automatic test_redirect_wait();
    @(negedge clk);
    drive_quiet(); pc_in = 32'h0040_0300; bus.imem_req_ready = 1'b1;
    @(negedge clk);
    pc_in = 32'h0040_0304; bus.imem_req_ready = 1'b0; redirect = 1'b1;
    #1;
    n_cmp++; if (pc_ena !== 1'b1) begin n_err++; $display("FAIL rdw_pc_ena: got %0b required 1", pc_ena); end
    @(negedge clk);
    pc_in = 32'h0040_0100; redirect = 1'b0; bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'hDEAD_BEEF;
    #1;
    n_cmp++; if (fsm_state !== DRAIN) begin n_err++; $display("FAIL rdw_drain: got %0d required DRAIN", fsm_state); end
    n_cmp++; if (bus.imem_req_valid !== 1'b0 || pc_ena !== 1'b0) begin n_err++; $display("FAIL rdw_drain_quiet: got req=%0b ena=%0b required 0 0", bus.imem_req_valid, pc_ena); end
    @(negedge clk);
    bus.imem_resp_valid = 1'b0; bus.imem_req_ready = 1'b1;
    #1;
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL rdw_dropped: got %0b required 0", bus.inst_valid); end
    n_cmp++; if (bus.imem_addr !== 32'h0040_0100 || pc_ena !== 1'b1) begin n_err++; $display("FAIL rdw_target_req: got addr=%h ena=%0b required 00400100 1", bus.imem_addr, pc_ena); end
    @(negedge clk);
    pc_in = 32'h0040_0104; bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'h2000_0001;
    @(negedge clk);
    bus.imem_resp_valid = 1'b0; bus.inst_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0040_0100 || bus.inst_out !== 32'h2000_0001) begin
      n_err++; $display("FAIL rdw_first_pc: got valid=%0b pc=%h inst=%h required 1 00400100 20000001", bus.inst_valid, bus.inst_pc, bus.inst_out);
    end
    @(negedge clk);
    bus.inst_ready = 1'b0;
    #1;
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL rdw_empty: got %0b required 0", bus.inst_valid); end
  endtask

  task automatic test_redirect_with_resp();
    @(negedge clk);
    drive_quiet(); pc_in = 32'h0040_0400; bus.imem_req_ready = 1'b1;
    @(negedge clk);
    pc_in = 32'h0040_0404; bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'hAAAA_0001;
    @(negedge clk);
    bus.imem_resp_valid = 1'b0; bus.imem_req_ready = 1'b1;
    #1;
    n_cmp++; if (bus.inst_valid !== 1'b1 || pc_ena !== 1'b1) begin n_err++; $display("FAIL rdr_setup: got valid=%0b ena=%0b required 1 1", bus.inst_valid, pc_ena); end
    @(negedge clk);
    pc_in = 32'h0040_0408; bus.imem_req_ready = 1'b0; redirect = 1'b1; bus.inst_ready = 1'b1;
    bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'hBBBB_0002;
    #1;
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL rdr_valid_forced: got %0b required 0", bus.inst_valid); end
    n_cmp++; if (pc_ena !== 1'b1 || bus.imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rdr_ena_req: got ena=%0b req=%0b required 1 0", pc_ena, bus.imem_req_valid); end
    @(negedge clk);
    pc_in = 32'h0040_0500; redirect = 1'b0; bus.imem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.inst_valid !== 1'b0 || fsm_state !== IDLE) begin
      n_err++; $display("FAIL rdr_flushed: got valid=%0b state=%0d required 0 IDLE", bus.inst_valid, fsm_state);
    end
    @(negedge clk);
    bus.inst_ready = 1'b0;
    #1;
    n_cmp++; if (bus.inst_valid !== 1'b0) begin n_err++; $display("FAIL rdr_no_stale: got %0b required 0", bus.inst_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_quiet(); pc_in = 32'h0040_0600; bus.imem_req_ready = 1'b1;
    @(negedge clk);
    pc_in = 32'h0040_0604; bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b1; bus.imem_resp_data = 32'hCCCC_0003;
    @(negedge clk);
    bus.imem_resp_valid = 1'b0; bus.imem_req_ready = 1'b1;
    @(negedge clk);
    pc_in = 32'h0040_0608; bus.imem_req_ready = 1'b0;
    #1;
    n_cmp++;
    if (fsm_state !== WAIT || bus.inst_valid !== 1'b1) begin
      n_err++; $display("FAIL rmid_setup: got state=%0d valid=%0b required WAIT 1", fsm_state, bus.inst_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 || pc_ena !== 1'b0 || fsm_state !== IDLE) begin
      n_err++; $display("FAIL rmid_reset: got valid=%0b req=%0b ena=%0b state=%0d required 0 0 0 IDLE",
                        bus.inst_valid, bus.imem_req_valid, pc_ena, fsm_state);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req_valid !== 1'b1) begin
      n_err++; $display("FAIL rmid_after: got valid=%0b req=%0b required 0 1", bus.inst_valid, bus.imem_req_valid);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    pc_in = 32'h0;
    drive_quiet();
    test_reset();
    test_basic_fetch();
    test_stall();
    test_slow_memory();
    test_redirect_wait();
    test_redirect_with_resp();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
